// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: buttons, board port, win-checker handshake and status of the game controller
interface turn_sequencer_if;
  logic       logic_0_button;
  logic       logic_1_button;
  logic       activity_button;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic [1:0] wr_piece;
  logic       chk_start;
  logic [3:0] chk_x;
  logic [3:0] chk_y;
  logic [1:0] chk_piece;
  logic       chk_done;
  logic       chk_win;
  logic       current_player;
  logic [4:0] moves_circles;
  logic [4:0] moves_triangles;
  logic [3:0] bit_count;
  logic       invalid_move;
  logic [1:0] game_outcome;
  logic [2:0] state_o;
  modport master (
    input  logic_0_button, logic_1_button, activity_button, rd_data, chk_done, chk_win,
    output rd_x, rd_y, wr_en, wr_x, wr_y, wr_piece, chk_start, chk_x, chk_y, chk_piece,
           current_player, moves_circles, moves_triangles, bit_count, invalid_move,
           game_outcome, state_o
  );
  modport slave (
    output logic_0_button, logic_1_button, activity_button, rd_data, chk_done, chk_win,
    input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_piece, chk_start, chk_x, chk_y, chk_piece,
           current_player, moves_circles, moves_triangles, bit_count, invalid_move,
           game_outcome, state_o
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: Triangles vs Circles controller - coordinate entry, move validation, board clear, turn order
module turn_sequencer #(
  parameter int BOARD_SIZE = 10,
  parameter int MAX_MOVES  = 25
) (
  input logic            clk,
  input logic            reset,
  turn_sequencer_if.master bus
);
  localparam logic [2:0] CLEAR = 3'd0, IDLE = 3'd1, ENTRY = 3'd2, LOOKUP = 3'd3,
                         VERIFY = 3'd4, WRITE = 3'd5, CHECK = 3'd6, GAME_OVER = 3'd7;
  localparam logic [3:0] LAST = 4'(BOARD_SIZE - 1);
  localparam logic [4:0] MAXM = 5'(MAX_MOVES);
  logic [2:0] state;
  logic [3:0] sx, sy, bit_count, chk_x, chk_y;
  logic [7:0] buffer;
  logic       player, invalid, chk_start;
  logic [4:0] mc, mt;
  logic [1:0] outcome, chk_piece;
  logic [3:0] bx, by;
  logic [1:0] piece;
  logic       act, tog, bad;
  assign bx    = buffer[7:4];
  assign by    = buffer[3:0];
  assign piece = player ? 2'b01 : 2'b10;
  assign act   = bus.activity_button;
  assign tog   = bus.logic_0_button ^ bus.logic_1_button;
  assign bad   = bx > LAST || by > LAST || bus.rd_data != 2'b00;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      sx        <= '0;
      sy        <= '0;
      buffer    <= '0;
      bit_count <= '0;
      player    <= 1'b0;
      mc        <= '0;
      mt        <= '0;
      outcome   <= 2'b00;
      invalid   <= 1'b0;
      chk_start <= 1'b0;
      chk_x     <= '0;
      chk_y     <= '0;
      chk_piece <= 2'b00;
    end else begin
      invalid   <= 1'b0;
      chk_start <= 1'b0;
      case (state)
        CLEAR:
          if (sx == LAST && sy == LAST) begin
            sx    <= '0;
            sy    <= '0;
            state <= IDLE;
          end else if (sy == LAST) begin
            sy <= '0;
            sx <= sx + 4'd1;
          end else sy <= sy + 4'd1;
        IDLE:
          if (act) begin
            state     <= ENTRY;
            player    <= 1'b0;
            mc        <= '0;
            mt        <= '0;
            outcome   <= 2'b00;
            buffer    <= '0;
            bit_count <= '0;
          end
        ENTRY:
          if (act) begin
            if (bit_count == 4'd8) state <= LOOKUP;
            else begin
              invalid   <= 1'b1;
              buffer    <= '0;
              bit_count <= '0;
            end
          end else if (tog && bit_count != 4'd8) begin
            buffer    <= {buffer[6:0], bus.logic_1_button};
            bit_count <= bit_count + 4'd1;
          end
        LOOKUP: state <= VERIFY;
        VERIFY:
          if (bad) begin
            invalid   <= 1'b1;
            buffer    <= '0;
            bit_count <= '0;
            state     <= ENTRY;
          end else state <= WRITE;
        WRITE: begin
          if (player) mt <= mt + 5'd1;
          else mc <= mc + 5'd1;
          chk_x     <= bx;
          chk_y     <= by;
          chk_piece <= piece;
          buffer    <= '0;
          bit_count <= '0;
          chk_start <= 1'b1;
          state     <= CHECK;
        end
        CHECK:
          if (bus.chk_done) begin
            if (bus.chk_win) begin
              outcome <= player ? 2'b10 : 2'b01;
              state   <= GAME_OVER;
            end else if (mt == MAXM) begin
              outcome <= 2'b11;
              state   <= GAME_OVER;
            end else begin
              player <= ~player;
              state  <= ENTRY;
            end
          end
        GAME_OVER: if (act) state <= CLEAR;
        default: state <= CLEAR;
      endcase
    end
  end
  // reset gates the strobe so the board sees no write while reset is held
  assign bus.wr_en           = !reset && (state == CLEAR || state == WRITE);
  assign bus.wr_x            = state == CLEAR ? sx : bx;
  assign bus.wr_y            = state == CLEAR ? sy : by;
  assign bus.wr_piece        = state == WRITE ? piece : 2'b00;
  assign bus.rd_x            = bx;
  assign bus.rd_y            = by;
  assign bus.chk_start       = chk_start;
  assign bus.chk_x           = chk_x;
  assign bus.chk_y           = chk_y;
  assign bus.chk_piece       = chk_piece;
  assign bus.current_player  = player;
  assign bus.moves_circles   = mc;
  assign bus.moves_triangles = mt;
  assign bus.bit_count       = bit_count;
  assign bus.invalid_move    = invalid;
  assign bus.game_outcome    = outcome;
  assign bus.state_o         = state;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: randomized games against a move-level reference model of the game rules
module tb_turn_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ref_player, ref_mc, ref_mt, ref_outcome;
  int   ref_board [10][10];
  logic [1:0] mem [16][16];
  turn_sequencer_if bus();
  turn_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_x][bus.wr_y] <= bus.wr_piece;
    bus.rd_data <= mem[bus.rd_x][bus.rd_y];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic a, input logic l0, input logic l1);
    bus.activity_button = a;
    bus.logic_0_button  = l0;
    bus.logic_1_button  = l1;
    tick;
    bus.activity_button = 1'b0;
    bus.logic_0_button  = 1'b0;
    bus.logic_1_button  = 1'b0;
  endtask
  task automatic enter_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) press(1'b0, !b[i], b[i]);
  endtask
  task automatic clear_refs;
    ref_player  = 0;
    ref_mc      = 0;
    ref_mt      = 0;
    ref_outcome = 0;
  endtask
  task automatic check_clear;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("clear_cell", {bus.wr_en, bus.wr_piece, bus.wr_x, bus.wr_y},
            {1'b1, 2'b00, 4'(i / 10), 4'(i % 10)});
    end
    @(negedge clk);
    check("clear_done", {bus.wr_en, bus.state_o}, {1'b0, 3'd1});
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 10; y++) ref_board[x][y] = 0;
  endtask
  task automatic check_reset_vals(input string tag);
    check(tag, {bus.state_o, bus.current_player, bus.moves_circles, bus.moves_triangles,
                bus.bit_count, bus.game_outcome, bus.wr_en, bus.chk_start, bus.invalid_move}, 0);
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    tick;
    reset = 1'b0;
    clear_refs;
    check_clear;
  endtask
  task automatic start_game;
    press(1'b1, 1'b0, 1'b0);
    clear_refs;
    check("game_start", {bus.state_o, bus.current_player, bus.moves_circles, bus.moves_triangles,
                         bus.game_outcome, bus.bit_count}, {3'd2, 1'b0, 5'd0, 5'd0, 2'b00, 4'd0});
  endtask
  task automatic expect_invalid(input string tag);
    bit si = 1'b0;
    bit sw = 1'b0;
    repeat (4) begin
      si |= bus.invalid_move;
      sw |= bus.wr_en;
      tick;
    end
    check(tag, {si, sw, bus.state_o, bus.bit_count, bus.current_player},
          {1'b1, 1'b0, 3'd2, 4'd0, 1'(ref_player)});
  endtask
  task automatic move(input int x, input int y, input bit win, input bit extra);
    logic [7:0] b;
    logic [1:0] pc;
    bit valid;
    int d;
    b = {x[3:0], y[3:0]};
    valid = x < 10 && y < 10;
    if (valid) valid = ref_board[x][y] == 0;
    pc = ref_player != 0 ? 2'b01 : 2'b10;
    enter_bits(b, 8);
    check("bits_in", bus.bit_count, 8);
    press(1'b1, 1'b0, extra);
    check("lookup_addr", {bus.state_o, bus.rd_x, bus.rd_y}, {3'd3, b});
    if (!valid) begin
      expect_invalid("rejected_move");
      return;
    end
    tick;
    tick;
    check("write", {bus.wr_en, bus.wr_piece, bus.wr_x, bus.wr_y}, {1'b1, pc, b});
    ref_board[x][y] = ref_player != 0 ? 1 : 2;
    if (ref_player != 0) ref_mt++;
    else ref_mc++;
    tick;
    check("chk_start", {bus.chk_start, bus.wr_en, bus.chk_piece, bus.chk_x, bus.chk_y}, {2'b10, pc, b});
    check("move_counts", {bus.moves_circles, bus.moves_triangles}, {5'(ref_mc), 5'(ref_mt)});
    d = $urandom_range(0, 3);
    repeat (d) tick;
    check("chk_hold", {bus.chk_start, bus.chk_piece, bus.chk_x, bus.chk_y}, {1'(d == 0), pc, b});
    bus.chk_done = 1'b1;
    bus.chk_win  = win;
    tick;
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    if (win) ref_outcome = ref_player != 0 ? 2 : 1;
    else if (ref_mt == 25) ref_outcome = 3;
    else ref_player ^= 1;
    check("after_check", {bus.state_o, bus.current_player, bus.game_outcome},
          {ref_outcome != 0 ? 3'd7 : 3'd2, 1'(ref_player), 2'(ref_outcome)});
  endtask
  task automatic rand_move(input bit allow_win);
    int x, y;
    if ($urandom_range(0, 4) == 0) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
    end else begin
      do begin
        x = $urandom_range(0, 9);
        y = $urandom_range(0, 9);
      end while (ref_board[x][y] != 0);
    end
    move(x, y, allow_win && ref_player == 0 && ref_mc >= 3, 1'($urandom_range(0, 1)));
  endtask
  initial begin
    bus.activity_button = 1'b0;
    bus.logic_0_button  = 1'b0;
    bus.logic_1_button  = 1'b0;
    bus.chk_done        = 1'b0;
    bus.chk_win         = 1'b0;
    clear_refs;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_vals");
    reset = 1'b0;
    check_clear;
    start_game;
    move(3, 5, 1'b0, 1'b0);
    move(3, 5, 1'b0, 1'b0);
    move(10, 0, 1'b0, 1'b0);
    enter_bits(8'b10110000, 5);
    check("five_bits", bus.bit_count, 5);
    press(1'b1, 1'b0, 1'b0);
    expect_invalid("short_commit");
    enter_bits(8'b01000000, 2);
    press(1'b0, 1'b1, 1'b1);
    check("both_logic", bus.bit_count, 2);
    press(1'b1, 1'b0, 1'b1);
    expect_invalid("act_plus_bit");
    move(7, 2, 1'b0, 1'b1);
    while (ref_outcome == 0) rand_move(1'b0);
    check("draw", {bus.state_o, bus.game_outcome, bus.moves_circles, bus.moves_triangles},
          {3'd7, 2'b11, 5'd25, 5'd25});
    press(1'b1, 1'b0, 1'b0);
    check_clear;
    start_game;
    while (ref_outcome == 0) rand_move(1'b1);
    check("circle_win", {bus.state_o, bus.game_outcome}, {3'd7, 2'b01});
    press(1'b1, 1'b0, 1'b0);
    repeat (37) tick;
    do_reset("reset_in_clear");
    start_game;
    enter_bits(8'h27, 8);
    press(1'b1, 1'b0, 1'b0);
    repeat (3) tick;
    check("pre_reset_chk", {bus.state_o, bus.chk_start}, {3'd6, 1'b1});
    do_reset("reset_in_check");
    bus.chk_done = 1'b1;
    bus.chk_win  = 1'b1;
    tick;
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    check("late_done", {bus.state_o, bus.game_outcome, bus.current_player}, {3'd1, 2'b00, 1'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
